// File: rtl/matmul_sequencer_if.sv
// Command handshake between decode/issue and the matrix sequencer.
interface matmul_sequencer_if #(
    parameter int unsigned IDX_W = 3
);
    logic             cmd_valid;
    logic [2:0]       cmd_opcode;
    logic [IDX_W-1:0] cmd_idx;
    logic             cmd_high_low;
    logic             cmd_ready;

    // Issue stage side
    modport master (
        output cmd_valid,
        output cmd_opcode,
        output cmd_idx,
        output cmd_high_low,
        input  cmd_ready
    );

    // Sequencer side
    modport slave (
        input  cmd_valid,
        input  cmd_opcode,
        input  cmd_idx,
        input  cmd_high_low,
        output cmd_ready
    );
endinterface

// File: rtl/matmul_sequencer.sv
// Matrix command sequencer: turns accepted commands into registered array strobes,
// runs the matmul step sequence and times the readC return.
module matmul_sequencer #(
    parameter int unsigned DIM      = 8,
    parameter int unsigned IDX_W    = $clog2(DIM),
    parameter int unsigned READ_LAT = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    matmul_sequencer_if.slave    cmd,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 arr_wr_a_o,
    output logic                 arr_wr_b_o,
    output logic                 arr_wr_c_o,
    output logic [IDX_W-1:0]     arr_wr_idx_o,
    output logic                 arr_step_o,
    output logic                 arr_rd_en_o,
    output logic [IDX_W-1:0]     arr_rd_idx_o,
    output logic                 arr_rd_high_low_o,
    output logic                 rd_valid_o,
    output logic                 done_o,
    output logic [4:0]           step_cnt_o,
    output logic [CNT_W-1:0]     matmul_count_o
);

    localparam logic [2:0] OpWriteA = 3'b001;
    localparam logic [2:0] OpWriteB = 3'b010;
    localparam logic [2:0] OpWriteC = 3'b011;
    localparam logic [2:0] OpMatmul = 3'b100;
    localparam logic [2:0] OpReadC  = 3'b101;
    localparam logic [2:0] OpStep   = 3'b110;

    localparam logic [4:0]      Steps = 5'(3 * DIM - 2);
    localparam int unsigned     RC_W  = $clog2(READ_LAT + 1);
    localparam logic [RC_W-1:0] RdLat = RC_W'(READ_LAT);
    localparam logic [RC_W-1:0] RcOne = RC_W'(1);

    typedef enum logic [1:0] {StIdle, StCompute, StRead} state_e;

    state_e           state_q, state_d;
    logic [4:0]       step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RC_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic             rd_hl_q, rd_hl_d;
    logic             wr_a_q, wr_a_d, wr_b_q, wr_b_d, wr_c_q, wr_c_d;
    logic             step_str_q, step_str_d, rd_en_q, rd_en_d;
    logic             rd_valid_q, rd_valid_d, done_q, done_d;
    logic             accept;
    logic [CNT_W-1:0] cnt_inc;

    // Ready is combinational so abort blocks acceptance in the same cycle
    assign cmd.cmd_ready = (state_q == StIdle) && !abort_i;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign cnt_inc       = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    // Next-state and strobe decode; strobes default low so each is a single pulse
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        cnt_d      = cnt_q;
        rd_cnt_d   = rd_cnt_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        rd_hl_d    = rd_hl_q;
        wr_a_d     = 1'b0;
        wr_b_d     = 1'b0;
        wr_c_d     = 1'b0;
        step_str_d = 1'b0;
        rd_en_d    = 1'b0;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        if (abort_i) begin
            state_d  = StIdle;
            step_d   = '0;
            rd_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        case (cmd.cmd_opcode)
                            OpWriteA: begin wr_a_d = 1'b1; wr_idx_d = cmd.cmd_idx; end
                            OpWriteB: begin wr_b_d = 1'b1; wr_idx_d = cmd.cmd_idx; end
                            OpWriteC: begin wr_c_d = 1'b1; wr_idx_d = cmd.cmd_idx; end
                            OpStep:   step_str_d = 1'b1;
                            OpMatmul: begin
                                state_d    = StCompute;
                                step_d     = 5'd1;
                                step_str_d = 1'b1;
                                if (Steps == 5'd1) begin
                                    done_d = 1'b1;
                                    cnt_d  = cnt_inc;
                                end
                            end
                            OpReadC: begin
                                state_d    = StRead;
                                rd_cnt_d   = RcOne;
                                rd_en_d    = 1'b1;
                                rd_idx_d   = cmd.cmd_idx;
                                rd_hl_d    = cmd.cmd_high_low;
                                rd_valid_d = (RdLat == RcOne);
                            end
                            default: ;
                        endcase
                    end
                end
                StCompute: begin
                    if (step_q >= Steps) begin
                        state_d = StIdle;
                    end else begin
                        step_d     = step_q + 5'd1;
                        step_str_d = 1'b1;
                        if (step_q + 5'd1 == Steps) begin
                            done_d = 1'b1;
                            cnt_d  = cnt_inc;
                        end
                    end
                end
                StRead: begin
                    if (rd_cnt_q >= RdLat) begin
                        state_d = StIdle;
                    end else begin
                        rd_cnt_d   = rd_cnt_q + RcOne;
                        rd_valid_d = (rd_cnt_q + RcOne == RdLat);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State, counters and registered strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            step_q     <= '0;
            cnt_q      <= '0;
            rd_cnt_q   <= '0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            rd_hl_q    <= 1'b0;
            wr_a_q     <= 1'b0;
            wr_b_q     <= 1'b0;
            wr_c_q     <= 1'b0;
            step_str_q <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            rd_hl_q    <= rd_hl_d;
            wr_a_q     <= wr_a_d;
            wr_b_q     <= wr_b_d;
            wr_c_q     <= wr_c_d;
            step_str_q <= step_str_d;
            rd_en_q    <= rd_en_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
        end
    end

    assign busy_o            = (state_q != StIdle);
    assign arr_wr_a_o        = wr_a_q;
    assign arr_wr_b_o        = wr_b_q;
    assign arr_wr_c_o        = wr_c_q;
    assign arr_wr_idx_o      = wr_idx_q;
    assign arr_step_o        = step_str_q;
    assign arr_rd_en_o       = rd_en_q;
    assign arr_rd_idx_o      = rd_idx_q;
    assign arr_rd_high_low_o = rd_hl_q;
    assign rd_valid_o        = rd_valid_q;
    assign done_o            = done_q;
    assign step_cnt_o        = step_q;
    assign matmul_count_o    = cnt_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench: directed test-plan steps followed by random commands, all compared
// against a per-cycle timeline of expected outputs built from the command rules.
module tb_matmul_sequencer;
    localparam int DIM      = 8;
    localparam int IDX_W    = 3;
    localparam int READ_LAT = 2;
    localparam int CNT_W    = 16;
    localparam int STEPS    = 3 * DIM - 2;
    localparam int MAXC     = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic abort = 1'b0;
    logic busy, wr_a, wr_b, wr_c, step, rd_en, rd_hl, rd_valid, done;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [4:0]       step_cnt;
    logic [CNT_W-1:0] mm_count;

    matmul_sequencer_if #(.IDX_W(IDX_W)) cmd_if ();

    matmul_sequencer #(.DIM(DIM), .IDX_W(IDX_W), .READ_LAT(READ_LAT), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .cmd               (cmd_if),
        .abort_i           (abort),
        .busy_o            (busy),
        .arr_wr_a_o        (wr_a),
        .arr_wr_b_o        (wr_b),
        .arr_wr_c_o        (wr_c),
        .arr_wr_idx_o      (wr_idx),
        .arr_step_o        (step),
        .arr_rd_en_o       (rd_en),
        .arr_rd_idx_o      (rd_idx),
        .arr_rd_high_low_o (rd_hl),
        .rd_valid_o        (rd_valid),
        .done_o            (done),
        .step_cnt_o        (step_cnt),
        .matmul_count_o    (mm_count)
    );

    always #5 clk = ~clk;

    // Expected-output timeline, indexed by cycle number
    bit e_wa[MAXC], e_wb[MAXC], e_wc[MAXC], e_step[MAXC], e_rd[MAXC];
    bit e_rdv[MAXC], e_done[MAXC], e_busy[MAXC], e_hl[MAXC];
    int e_widx[MAXC], e_ridx[MAXC], e_sc[MAXC], e_cnt[MAXC];

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Compare every output against the timeline, then advance the model with this
    // cycle's inputs and move to just after the next rising edge.
    task automatic tick();
        bit ready;
        int v;
        @(negedge clk);
        ready = !e_busy[cyc] && !abort;
        chk("cmd_ready", 32'(cmd_if.cmd_ready), 32'(ready));
        chk("busy", 32'(busy), 32'(e_busy[cyc]));
        chk("arr_wr_a", 32'(wr_a), 32'(e_wa[cyc]));
        chk("arr_wr_b", 32'(wr_b), 32'(e_wb[cyc]));
        chk("arr_wr_c", 32'(wr_c), 32'(e_wc[cyc]));
        chk("arr_wr_idx", 32'(wr_idx), 32'(e_widx[cyc]));
        chk("arr_step", 32'(step), 32'(e_step[cyc]));
        chk("arr_rd_en", 32'(rd_en), 32'(e_rd[cyc]));
        chk("arr_rd_idx", 32'(rd_idx), 32'(e_ridx[cyc]));
        chk("arr_rd_high_low", 32'(rd_hl), 32'(e_hl[cyc]));
        chk("rd_valid", 32'(rd_valid), 32'(e_rdv[cyc]));
        chk("done", 32'(done), 32'(e_done[cyc]));
        chk("step_cnt", 32'(step_cnt), 32'(e_sc[cyc]));
        chk("matmul_count", 32'(mm_count), 32'(e_cnt[cyc]));
        if (abort) begin
            // Cancel everything still in flight; the count keeps its present value
            for (int i = cyc + 1; i < MAXC; i++) begin
                e_step[i] = 0; e_done[i] = 0; e_rdv[i] = 0; e_rd[i] = 0;
                e_busy[i] = 0; e_sc[i] = 0; e_cnt[i] = e_cnt[cyc];
            end
        end else if (cmd_if.cmd_valid && ready) begin
            case (cmd_if.cmd_opcode)
                3'b001, 3'b010, 3'b011: begin
                    if (cmd_if.cmd_opcode == 3'b001) e_wa[cyc + 1] = 1;
                    if (cmd_if.cmd_opcode == 3'b010) e_wb[cyc + 1] = 1;
                    if (cmd_if.cmd_opcode == 3'b011) e_wc[cyc + 1] = 1;
                    for (int i = cyc + 1; i < MAXC; i++) e_widx[i] = int'(cmd_if.cmd_idx);
                end
                3'b100: begin
                    for (int k = 1; k <= STEPS; k++) begin
                        e_step[cyc + k] = 1;
                        e_busy[cyc + k] = 1;
                        e_sc[cyc + k]   = k;
                    end
                    for (int i = cyc + STEPS + 1; i < MAXC; i++) e_sc[i] = STEPS;
                    e_done[cyc + STEPS] = 1;
                    v = e_cnt[cyc] + 1;
                    if (v > (1 << CNT_W) - 1) v = (1 << CNT_W) - 1;
                    for (int i = cyc + STEPS; i < MAXC; i++) e_cnt[i] = v;
                end
                3'b101: begin
                    e_rd[cyc + 1] = 1;
                    for (int k = 1; k <= READ_LAT; k++) e_busy[cyc + k] = 1;
                    e_rdv[cyc + READ_LAT] = 1;
                    for (int i = cyc + 1; i < MAXC; i++) begin
                        e_ridx[i] = int'(cmd_if.cmd_idx);
                        e_hl[i]   = cmd_if.cmd_high_low;
                    end
                end
                3'b110: e_step[cyc + 1] = 1;
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Asynchronous reset pulse mid-cycle: outputs must clear without waiting for a clock edge
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_idx", 32'(rd_idx), 32'd0);
        chk("rst_step_cnt", 32'(step_cnt), 32'd0);
        chk("rst_matmul_count", 32'(mm_count), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_if.cmd_ready), 32'(!abort));
        for (int i = cyc; i < MAXC; i++) begin
            e_wa[i] = 0; e_wb[i] = 0; e_wc[i] = 0; e_step[i] = 0; e_rd[i] = 0;
            e_rdv[i] = 0; e_done[i] = 0; e_busy[i] = 0; e_hl[i] = 0;
            e_widx[i] = 0; e_ridx[i] = 0; e_sc[i] = 0; e_cnt[i] = 0;
        end
        rst = 1'b0;
    endtask

    task automatic drive(input bit v, input bit [2:0] op, input int idx, input bit hl);
        cmd_if.cmd_valid    = v;
        cmd_if.cmd_opcode   = op;
        cmd_if.cmd_idx      = IDX_W'(idx);
        cmd_if.cmd_high_low = hl;
    endtask

    initial begin
        drive(0, 3'b000, 0, 0);
        @(posedge clk);
        #1;
        do_reset();
        repeat (2) tick();

        // writeA idx 3: single strobe, never busy
        drive(1, 3'b001, 3, 0); tick();
        drive(0, 3'b000, 0, 0); repeat (2) tick();

        // Four back-to-back writeB rows
        for (int i = 0; i < 4; i++) begin
            drive(1, 3'b010, i, 0);
            tick();
        end
        drive(1, 3'b011, 6, 0); tick();
        drive(0, 3'b000, 0, 0); tick();

        // matmul, with a readC held on the bus for the whole busy window
        drive(1, 3'b100, 0, 0); tick();
        drive(1, 3'b101, 5, 1);
        repeat (STEPS + 1) tick();
        drive(0, 3'b000, 0, 0);
        repeat (4) tick();
        chk("matmul_count_after_first", 32'(mm_count), 32'd1);

        // matmul aborted at step 10
        drive(1, 3'b100, 0, 0); tick();
        drive(0, 3'b000, 0, 0);
        repeat (9) tick();
        chk("step_cnt_before_abort", 32'(step_cnt), 32'd10);
        abort = 1'b1; tick();
        abort = 1'b0;
        chk("step_cnt_after_abort", 32'(step_cnt), 32'd0);
        repeat (STEPS) tick();
        chk("matmul_count_after_abort", 32'(mm_count), 32'd1);

        // systolicstep in IDLE, then a no-op opcode
        drive(1, 3'b110, 0, 0); tick();
        drive(0, 3'b000, 0, 0); repeat (2) tick();
        drive(1, 3'b111, 2, 1); tick();
        drive(0, 3'b000, 0, 0); repeat (2) tick();

        // readC interrupted by reset while in READ
        drive(1, 3'b101, 7, 1); tick();
        drive(0, 3'b000, 0, 0);
        do_reset();
        repeat (4) tick();

        // Random command stream with occasional aborts
        for (int n = 0; n < 500; n++) begin
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            abort = ($urandom_range(0, 19) == 0);
            tick();
        end
        abort = 1'b0;
        drive(0, 3'b000, 0, 0);
        repeat (STEPS + 2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Sits between decode/issue and the systolic matrix unit.
- Accepts one matrix command per handshake: writeA, writeB, writeC, matmul, readC or systolicstep.
- Generates registered per-cycle strobes for the array, runs the multi-cycle matmul step sequence, times the readC return, and back-pressures the pipeline via cmd_ready while the array is busy.

Parameters:
- DIM, 8, systolic array dimension (rows = cols).
- IDX_W, $clog2(DIM), row index width.
- READ_LAT, 2, array read latency in cycles, from arr_rd_en to data valid; must be >= 1.
- CNT_W, 16, width of the completed-matmul counter.

Ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- cmd_valid  in  1  command present
- cmd_opcode  in  3  001 writeA, 010 writeB, 011 writeC, 100 matmul, 101 readC, 110 systolicstep; 000/111 no-op
- cmd_idx  in  IDX_W  row index for write/read
- cmd_high_low  in  1  readC half select
- abort  in  1  synchronous cancel of any operation in progress
- cmd_ready  out  1  command can be accepted
- busy  out  1  state != IDLE
- arr_wr_a  out  1  write row into A buffer
- arr_wr_b  out  1  write row into B buffer
- arr_wr_c  out  1  write row into C accumulators
- arr_wr_idx  out  IDX_W  write row index
- arr_step  out  1  advance systolic array one step
- arr_rd_en  out  1  start C row read
- arr_rd_idx  out  IDX_W  read row index
- arr_rd_high_low  out  1  read half select
- rd_valid  out  1  readC data valid pulse
- done  out  1  matmul complete pulse
- step_cnt  out  5  steps issued in current matmul
- matmul_count  out  CNT_W  completed matmuls, saturating

Behaviour:
- Reset: state IDLE; all outputs and counters 0.
  - Exception: cmd_ready = 1 from reset, because it is purely combinational (state == IDLE) && !abort.
- Accept: a command is accepted when cmd_valid && cmd_ready.
  - Opcodes 000/111 are accepted with no effect.
- States: IDLE, COMPUTE, READ.
- IDLE, write opcodes: accepted at cycle T.
  - The matching arr_wr_* strobe is high for exactly cycle T+1.
  - arr_wr_idx = captured cmd_idx; it holds its value otherwise.
  - State stays IDLE, so back-to-back writes run at one per cycle.
- IDLE, systolicstep: accepted at T → arr_step high at T+1 only; state stays IDLE; step_cnt unchanged.
- IDLE, matmul: accepted at T.
  - Enter COMPUTE at T+1.
  - arr_step is high every COMPUTE cycle; step_cnt increments 1..STEPS, where STEPS = 3*DIM-2 (22 at default).
  - On the cycle step_cnt reaches STEPS: done pulses, matmul_count increments (saturating at all-ones), and the next state is IDLE.
  - cmd_ready is low T+1..T+STEPS.
- IDLE, readC: accepted at T.
  - arr_rd_en high at T+1 only; arr_rd_idx and arr_rd_high_low are captured and held until the next readC.
  - State is READ for T+1..T+READ_LAT.
  - rd_valid pulses at T+READ_LAT; IDLE at T+READ_LAT+1.
  - With READ_LAT = 1, arr_rd_en and rd_valid are high in the same cycle.
- Non-IDLE states: cmd_ready = 0, so no command of any kind is accepted. The issuing stage holds cmd_* stable.
- abort:
  - Forces cmd_ready low in the same cycle.
  - Next cycle: state IDLE, step_cnt 0, and all strobes are low. No done or rd_valid is produced for the cancelled operation.
  - matmul_count is unchanged.
- Reset mid-COMPUTE or mid-READ: immediate return to reset values.
- Strobes arr_wr_*, arr_step, arr_rd_en, done and rd_valid are registered and glitch-free. At most one array strobe class is active per cycle.

Test Plan:
- Reset, then writeA idx 3 at T → arr_wr_a=1, arr_wr_idx=3 at T+1 only; cmd_ready stays 1; busy 0.
- Four back-to-back writeB idx 0..3 → arr_wr_b high four consecutive cycles with idx 0,1,2,3.
- matmul at T → arr_step high T+1..T+22; step_cnt reaches 22; done at T+22; matmul_count=1; cmd_ready=1 at T+23. A readC held on cmd_valid during this window is accepted only at T+23.
- readC idx 5, high_low=1 at T (READ_LAT=2) → arr_rd_en, arr_rd_idx=5, arr_rd_high_low=1 at T+1; rd_valid at T+2; cmd_ready 0 at T+1..T+2.
- matmul, then abort at step 10 → arr_step low next cycle; state IDLE; no done; matmul_count unchanged; step_cnt=0.
- systolicstep in IDLE → one arr_step pulse, state unchanged. Opcode 111 → accepted, no strobe. rst asserted mid-READ → all outputs 0 immediately, rd_valid never pulses.
